// File: rtl/reset_sequencer.sv
// Reset sequencer: holds all domain resets after any reset source, then releases them stage 0 first.
// Optional RST_SEQ_ACK_EN adds ack_i so each release waits for the previous stage to acknowledge.
module reset_sequencer #(
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ext_rst_i,
    input  logic                  soft_req_i,
`ifdef RST_SEQ_ACK_EN
    input  logic [NUM_STAGES-1:0] ack_i,
`endif
    output logic [NUM_STAGES-1:0] rst_o,
    output logic                  done_o
);

    localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int IW      = $clog2(NUM_STAGES + 1);

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ASSERT,
        RELEASE,
        RUN
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            count_q, count_d;
    logic [IW-1:0]            stageIdx_q, stageIdx_d;
    logic [NUM_STAGES-1:0]    rst_q, rst_d;
    logic                     done_q, done_d;
    logic [SYNC_STAGES-1:0]   extSync_q;
    logic                     extSync;
    logic                     releaseOk;

    assign extSync = extSync_q[SYNC_STAGES-1];

    // The highest released stage sits just below the lowest asserted bit of rst_q.
`ifdef RST_SEQ_ACK_EN
    assign releaseOk = |(ack_i & ~rst_q & (rst_q >> 1));
`else
    assign releaseOk = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ASSERT;
            count_q    <= HOLD_LOAD;
            stageIdx_q <= '0;
            rst_q      <= '1;
            done_q     <= 1'b0;
            extSync_q  <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            stageIdx_q <= stageIdx_d;
            rst_q      <= rst_d;
            done_q     <= done_d;
            extSync_q  <= {extSync_q[SYNC_STAGES-2:0], ext_rst_i};
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        stageIdx_d = stageIdx_q;
        rst_d      = rst_q;
        done_d     = done_q;

        if (extSync || soft_req_i) begin
            state_d    = ASSERT;
            count_d    = HOLD_LOAD;
            stageIdx_d = '0;
            rst_d      = '1;
            done_d     = 1'b0;
        end else begin
            unique case (state_q)
                ASSERT: begin
                    if (count_q != '0) begin
                        count_d = count_q - CW'(1);
                    end else begin
                        rst_d = rst_q << 1;
                        if (NUM_STAGES == 1) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d    = RELEASE;
                            stageIdx_d = IW'(1);
                            count_d    = GAP_LOAD;
                        end
                    end
                end
                RELEASE: begin
                    // With acks enabled the counter parks at zero until the previous stage answers.
                    if (count_q != '0) begin
                        count_d = count_q - CW'(1);
                    end else if (releaseOk) begin
                        rst_d      = rst_q << 1;
                        stageIdx_d = stageIdx_q + IW'(1);
                        count_d    = GAP_LOAD;
                        if (stageIdx_q == LAST_IDX) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end
                    end
                end
                RUN: begin
                    rst_d  = '0;
                    done_d = 1'b1;
                end
                default: begin
                    state_d    = ASSERT;
                    count_d    = HOLD_LOAD;
                    stageIdx_d = '0;
                    rst_d      = '1;
                    done_d     = 1'b0;
                end
            endcase
        end
    end

    assign rst_o  = rst_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default 3-stage instance plus a 1-stage, 1-cycle-hold instance.
// Exercises the RST_SEQ_ACK_EN handshake when that macro is defined for the build.
module tb_reset_sequencer;

    logic       clk;
    logic       reset;
    logic       extRst;
    logic       softReq;
    logic [2:0] rstOut;
    logic       doneOut;
    logic       extRstSmall;
    logic       softReqSmall;
    logic [0:0] rstSmall;
    logic       doneSmall;
    int         checks;
    int         failures;
`ifdef RST_SEQ_ACK_EN
    logic [2:0] ackVec;
    logic [0:0] ackSmall;
`endif

    reset_sequencer #(
        .NUM_STAGES (3),
        .HOLD_CYCLES(8),
        .GAP_CYCLES (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ext_rst_i (extRst),
        .soft_req_i(softReq),
`ifdef RST_SEQ_ACK_EN
        .ack_i     (ackVec),
`endif
        .rst_o     (rstOut),
        .done_o    (doneOut)
    );

    reset_sequencer #(
        .NUM_STAGES (1),
        .HOLD_CYCLES(1),
        .GAP_CYCLES (4),
        .SYNC_STAGES(2)
    ) dutSmall (
        .clk       (clk),
        .reset     (reset),
        .ext_rst_i (extRstSmall),
        .soft_req_i(softReqSmall),
`ifdef RST_SEQ_ACK_EN
        .ack_i     (ackSmall),
`endif
        .rst_o     (rstSmall),
        .done_o    (doneSmall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drives the inputs, lets one rising edge happen, then settles before sampling.
    task automatic applyStimulus(input logic resetVal, input logic softVal, input logic extVal);
        reset   = resetVal;
        softReq = softVal;
        extRst  = extVal;
        @(posedge clk);
        #1;
    endtask

    // Hand-derived release timeline for the default instance, r = edges since the restart.
    function automatic logic [2:0] expRst(input int r);
        if (r < 8)       return 3'b111;
        else if (r < 12) return 3'b110;
        else if (r < 16) return 3'b100;
        else             return 3'b000;
    endfunction

    task automatic runSequence(input bit checkSmall);
        for (int r = 1; r <= 16; r++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("seq_rst_r%0d", r), 32'(rstOut), 32'(expRst(r)));
            checkOutput($sformatf("seq_done_r%0d", r), 32'(doneOut), 32'(r >= 16));
            if (checkSmall && r == 1) begin
                checkOutput("small_rst_edge1", 32'(rstSmall), 32'd0);
                checkOutput("small_done_edge1", 32'(doneSmall), 32'd1);
            end
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b0;
        extRst       = 1'b0;
        softReq      = 1'b0;
        extRstSmall  = 1'b0;
        softReqSmall = 1'b0;
`ifdef RST_SEQ_ACK_EN
        ackVec       = 3'b111;
        ackSmall     = 1'b1;
`endif

        $display("[TB] power-on reset and first release");
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("reset_rst", 32'(rstOut), 32'h7);
        checkOutput("reset_done", 32'(doneOut), 32'd0);
        checkOutput("small_reset_rst", 32'(rstSmall), 32'd1);
        checkOutput("small_reset_done", 32'(doneSmall), 32'd0);
        runSequence(1'b1);

        $display("[TB] external reset held in RUN");
        repeat (2) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("run_stable_rst", 32'(rstOut), 32'd0);
            checkOutput("run_stable_done", 32'(doneOut), 32'd1);
        end
        for (int e = 1; e <= 20; e++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            checkOutput($sformatf("ext_rst_e%0d", e), 32'(rstOut), (e < 3) ? 32'd0 : 32'h7);
            checkOutput($sformatf("ext_done_e%0d", e), 32'(doneOut), (e < 3) ? 32'd1 : 32'd0);
        end
        for (int e = 21; e <= 22; e++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("ext_tail_e%0d", e), 32'(rstOut), 32'h7);
        end
        runSequence(1'b0);

        $display("[TB] soft request mid-release");
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rereset_rst", 32'(rstOut), 32'h7);
        for (int r = 1; r <= 10; r++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("pre_soft_r%0d", r), 32'(rstOut), 32'(expRst(r)));
        end
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("soft_rst", 32'(rstOut), 32'h7);
        checkOutput("soft_done", 32'(doneOut), 32'd0);
        runSequence(1'b0);

        $display("[TB] master reset mid-release");
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("soft_from_run_rst", 32'(rstOut), 32'h7);
        for (int r = 1; r <= 12; r++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("pre_reset_r%0d", r), 32'(rstOut), 32'(expRst(r)));
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("mid_reset_rst", 32'(rstOut), 32'h7);
        checkOutput("mid_reset_done", 32'(doneOut), 32'd0);
        checkOutput("small_mid_reset_rst", 32'(rstSmall), 32'd1);
        runSequence(1'b1);

`ifdef RST_SEQ_ACK_EN
        $display("[TB] acknowledge handshake");
        ackVec = 3'b000;
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int r = 1; r <= 30; r++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("ack_wait_r%0d", r), 32'(rstOut), (r < 8) ? 32'h7 : 32'h6);
        end
        ackVec = 3'b001;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("ack0_release", 32'(rstOut), 32'h4);
        ackVec = 3'b011;
        for (int r = 32; r <= 35; r++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("ack1_rst_r%0d", r), 32'(rstOut), (r < 35) ? 32'h4 : 32'h0);
            checkOutput($sformatf("ack1_done_r%0d", r), 32'(doneOut), (r < 35) ? 32'd0 : 32'd1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
